// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Merges the ID
//   hazard request, the iterative mult/div unit in EX and the data-memory
//   wait handshake in MEM into one set of pipeline-register write/clear
//   enables, and sequences the mult/div occupancy counter.
//
// Ports
//   clk, rstn          clock (rising edge), async active-low reset
//   hz_stall           ID load-use/branch hazard stall request
//   br_taken           branch/jump redirect resolved in ID
//   md_start           EX holds a valid mult/div instruction
//   md_is_div          1=divide, 0=multiply (valid with md_start)
//   dmem_req           MEM stage accessing data memory
//   dmem_ready         data memory completes the access this cycle
//   PCWr .. MEMWBWrite pipeline-register write / clear enables
//   md_busy            mult/div operation in progress
//   md_done            one-cycle pulse, mult/div result valid
//   md_cnt             remaining mult/div cycles
//   cnt_hz/md/mem      saturating stall counters (STALL_PERF_CNT_EN only)
//
// Build option
//   STALL_PERF_CNT_EN  adds the three 32-bit stall performance counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | no mult/div in flight; a new one may start
// MD_BUSY  | mult/div in flight, md_cnt counting down
// MEM_WAIT | memory freeze; savedBusyQ remembers whether to resume MD_BUSY
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWr,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXWrite,
  output logic             IDEXClearCtrl,
  output logic             EXMEMWrite,
  output logic             EXMEMClear,
  output logic             MEMWBWrite,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] md_cnt
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]      cnt_hz,
  output logic [31:0]      cnt_md,
  output logic [31:0]      cnt_mem
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } stateT;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  stateT            stateQ, stateD;
  logic             savedBusyQ, savedBusyD;
  logic [CNT_W-1:0] cntQ, cntD;

  logic             memStall;
  logic             mdStall;
  logic             hzGov;
  logic             anyStall;
  logic             effBusy;
  logic             mdDone;
  logic [CNT_W-1:0] loadVal;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stateQ     <= RUN;
      savedBusyQ <= 1'b0;
      cntQ       <= '0;
    end else begin
      stateQ     <= stateD;
      savedBusyQ <= savedBusyD;
      cntQ       <= cntD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    savedBusyD = savedBusyQ;
    cntD       = cntQ;
    mdStall    = 1'b0;
    mdDone     = 1'b0;
    md_cnt     = cntQ;

    memStall = dmem_req && !dmem_ready;
    // MEM_WAIT acts as the saved state once the memory releases, so the
    // release cycle does real work instead of costing an extra bubble.
    effBusy  = (stateQ == MD_BUSY) || (stateQ == MEM_WAIT && savedBusyQ);
    loadVal  = md_is_div ? DIV_LOAD : MULT_LOAD;

    if (memStall) begin
      stateD     = MEM_WAIT;
      savedBusyD = effBusy;
    end else if (effBusy) begin
      if (cntQ != '0) begin
        mdStall = 1'b1;
        cntD    = cntQ - 1'b1;
        stateD  = MD_BUSY;
      end else begin
        mdDone  = 1'b1;
        stateD  = RUN;
      end
    end else begin
      stateD = RUN;
      // The start cycle is the first of the N occupancy cycles, so it shows
      // N-1 remaining and the register enters MD_BUSY one lower.
      if (md_start && rstn) begin
        md_cnt = loadVal;
        if (loadVal == '0) begin
          mdDone = 1'b1;
        end else begin
          mdStall = 1'b1;
          cntD    = loadVal - 1'b1;
          stateD  = MD_BUSY;
        end
      end
    end

    hzGov    = hz_stall && !memStall && !mdStall;
    anyStall = memStall || mdStall || hz_stall;

    PCWr          = 1'b1;
    IFIDWrite     = 1'b1;
    IFIDFlush     = 1'b0;
    IDEXWrite     = 1'b1;
    IDEXClearCtrl = 1'b0;
    EXMEMWrite    = 1'b1;
    EXMEMClear    = 1'b0;
    MEMWBWrite    = 1'b1;

    if (memStall) begin
      PCWr       = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      MEMWBWrite = 1'b0;
    end else if (mdStall) begin
      // ID/EX is held, so a concurrent hazard needs no control clear.
      PCWr       = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      EXMEMClear = 1'b1;
    end else if (hzGov) begin
      PCWr          = 1'b0;
      IFIDWrite     = 1'b0;
      IDEXClearCtrl = 1'b1;
    end else if (br_taken && !anyStall) begin
      IFIDFlush = 1'b1;
    end

    md_busy = effBusy;
    md_done = mdDone && rstn;
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_hz  <= '0;
      cnt_md  <= '0;
      cnt_mem <= '0;
    end else begin
      if (hzGov && cnt_hz != '1)                cnt_hz  <= cnt_hz + 32'd1;
      if (mdStall && !memStall && cnt_md != '1) cnt_md  <= cnt_md + 32'd1;
      if (memStall && cnt_mem != '1)            cnt_mem <= cnt_mem + 32'd1;
    end
  end
`endif

endmodule
